// File: rtl/regfile_debug_ctrl_pkg.sv
// Shared definitions for the MIPS debug controllers (register dump now,
// memory dump later): FSM state encoding and default geometry.
package mips_debug_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int REGFILE_WIDTH_DEF = 5;
  localparam int NUM_REGS          = 2 ** REGFILE_WIDTH_DEF;
  localparam int BYTES_PER_WORD    = DATA_WIDTH_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STALL = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } dbg_state_e;

  // Bytes in a word of the given width (width is a multiple of 8).
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/regfile_debug_ctrl_if.sv
// Byte stream link from the debug controller to the debug UART.
//
// Handshake: a byte transfers in every cycle where txValid and txReady are
// both high at the rising clock edge. Once txValid is raised, txValid and
// txByte hold steady until that transfer; txValid only drops without a
// transfer when reset is asserted. txReady may change freely.
interface regfile_debug_ctrl_if;

  logic [7:0] txByte;
  logic       txValid;
  logic       txReady;

  modport master (output txByte, output txValid, input txReady);
  modport slave  (input txByte, input txValid, output txReady);

endinterface

// File: rtl/regfile_debug_ctrl_serializer.sv
// Word-to-byte serializer: captures one register word and shifts it out
// MSB byte first over the tx link while the controller is in SEND.
module regword_serializer
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  send_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic                  last_o,
  regfile_debug_ctrl_if.master  tx
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
  logic                  valid;
  logic                  fire;

  // Reset masks valid combinationally so an abandoned byte disappears at once.
  assign valid      = send_i & ~reset;
  assign fire       = valid & tx.txReady;
  assign tx.txValid = valid;
  assign tx.txByte  = valid ? shift_q[DATA_WIDTH-1 -: 8] : 8'h00;
  assign last_o     = fire && (byte_cnt_q == CW'(BPW - 1));

  // Next state: load a fresh word, or shift one byte out per accepted transfer.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (load_i) begin
      shift_d    = word_i;
      byte_cnt_d = '0;
    end else if (fire) begin
      shift_d    = shift_q << 8;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  // Shift register and byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/regfile_debug_ctrl.sv
// Register bank debug controller: gates the bank clock enable in run and
// single-step modes, and on request halts the core and dumps all registers
// as bytes to the debug UART, borrowing read port A for the dump.
module regfile_debug_ctrl
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int REGFILE_WIDTH = REGFILE_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     runMode,
  input  logic                     stepReq,
  input  logic                     dumpReq,
  input  logic [REGFILE_WIDTH-1:0] pipeAddrA,
  input  logic [DATA_WIDTH-1:0]    regA,
  output logic [REGFILE_WIDTH-1:0] addressA,
  output logic                     clkEnable,
  regfile_debug_ctrl_if.master     tx,
  output logic                     busy,
  output logic                     done,
  output dbg_state_e               dbg_state_o
);

  localparam int NREGS = 2 ** REGFILE_WIDTH;
  localparam logic [REGFILE_WIDTH-1:0] LAST_IDX = REGFILE_WIDTH'(NREGS - 1);

  dbg_state_e               state_q, state_d;
  logic [REGFILE_WIDTH-1:0] idx_q, idx_d;
  logic                     step_q;
  logic                     step_pulse_q, step_pulse_d;
  logic                     step_rise;
  logic                     load;
  logic                     send;
  logic                     last;
  logic                     sel_idx;
  logic                     ce_raw;
  logic                     done_raw;

  assign step_rise = stepReq & ~step_q;

  regword_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .send_i (send),
    .word_i (regA),
    .last_o (last),
    .tx     (tx)
  );

  // State, register index and step-edge tracking. step_q follows stepReq
  // in every state so a level held across a dump never counts as a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      step_q       <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      step_q       <= stepReq;
      step_pulse_q <= step_pulse_d;
    end
  end

  // Next-state and control decode. The step pulse is registered, so a rise
  // sampled at one edge enables the bank for exactly the following cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    step_pulse_d = 1'b0;
    load         = 1'b0;
    send         = 1'b0;
    sel_idx      = 1'b0;
    ce_raw       = 1'b0;
    done_raw     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ce_raw = runMode | step_pulse_q;
        if (dumpReq) begin
          // A dump request swallows a coincident step edge.
          state_d = ST_STALL;
        end else begin
          step_pulse_d = step_rise;
        end
      end
      ST_STALL: begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sel_idx = 1'b1;
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        send = 1'b1;
        if (last) begin
          // Completion is decided on the compare so idx never needs to wrap.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        done_raw = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The bank runs its own reset clear, so it stays enabled during reset.
  assign clkEnable   = reset | ce_raw;
  assign addressA    = (sel_idx & ~reset) ? idx_q : pipeAddrA;
  assign busy        = ~reset & (state_q != ST_IDLE);
  assign done        = ~reset & done_raw;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_debug_ctrl.sv
// Bench for regfile_debug_ctrl: table-driven step/run vectors plus dump
// sequences checked against a byte scoreboard built from a bank model.
module tb_regfile_debug_ctrl;
  import mips_debug_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        runMode;
  logic        stepReq;
  logic        dumpReq;
  logic [4:0]  pipeAddrA;
  logic [4:0]  addressA;
  logic [31:0] regA;
  logic        clkEnable;
  logic        busy;
  logic        done;
  dbg_state_e  dbg_state;

  regfile_debug_ctrl_if tx_if ();

  always #5 clk = ~clk;

  logic [31:0] bank [32];
  assign regA = bank[addressA];

  regfile_debug_ctrl #(
    .DATA_WIDTH    (32),
    .REGFILE_WIDTH (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .runMode     (runMode),
    .stepReq     (stepReq),
    .dumpReq     (dumpReq),
    .pipeAddrA   (pipeAddrA),
    .regA        (regA),
    .addressA    (addressA),
    .clkEnable   (clkEnable),
    .tx          (tx_if.master),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  typedef struct {
    logic       run;
    logic       step;
    logic [4:0] addr;
    logic       exp_ce;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called once per cycle at the falling edge during dumps.
  task automatic check_tx();
    logic [7:0] e;
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("tx_hold_valid", 32'(tx_if.txValid), 32'd1);
        chk("tx_hold_byte", 32'(tx_if.txByte), 32'(prev_byte));
      end
      if (tx_if.txValid && tx_if.txReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra_byte actual=%0h expected=none at %0t", tx_if.txByte, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(tx_if.txByte), 32'(e));
        end
      end
      prev_valid = tx_if.txValid;
      prev_ready = tx_if.txReady;
      prev_byte  = tx_if.txByte;
    end
  endtask

  // Runs one dump. Cycle c counts clock edges after the edge that samples
  // dumpReq. rdy_mode 0: txReady always 1; 1: txReady high 1 cycle in 3.
  task automatic run_dump(input int rdy_mode, input bit collide, input int redump_at,
                          input int abort_at, output int done_cyc, output int done_cnt,
                          output int ce_cnt);
    int post;
    for (int i = 0; i < 32; i++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(bank[i][b*8 +: 8]);
    @(posedge clk); #1;
    dumpReq = 1'b1;
    if (collide) stepReq = 1'b1;
    tx_if.txReady = 1'b1;
    @(negedge clk);
    check_tx();
    @(posedge clk);
    done_cyc = -1;
    done_cnt = 0;
    ce_cnt   = 0;
    post     = 0;
    for (int c = 1; c < 1500 && post < 4; c++) begin
      #1;
      dumpReq       = (redump_at > 0 && c >= redump_at && c < redump_at + 3);
      tx_if.txReady = (rdy_mode == 0) ? 1'b1 : ((c % 3) == 0);
      reset         = (abort_at > 0 && c == abort_at);
      @(negedge clk);
      check_tx();
      if (c == 1) begin
        chk("dump_stall_state", 32'(dbg_state), 32'(ST_STALL));
        chk("dump_busy", 32'(busy), 32'd1);
      end
      if (c == 2) begin
        chk("dump_load_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("dump_load_addr", 32'(addressA), 32'd0);
      end
      if (abort_at > 0 && c == abort_at) begin
        chk("abort_txvalid", 32'(tx_if.txValid), 32'd0);
        chk("abort_clken", 32'(clkEnable), 32'd1);
        exp_q.delete();
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_txvalid_after", 32'(tx_if.txValid), 32'd0);
      end
      if (!reset && clkEnable) ce_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 || (abort_at > 0 && c > abort_at + 20)) post++;
      @(posedge clk);
    end
    #1;
    dumpReq = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dc, dn, ce;

    // Step/run vectors: exp_ce is clkEnable in the cycle the entry is applied.
    vecs[0]  = '{1'b0, 1'b0, 5'd3,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 5'd7,  1'b1};
    vecs[3]  = '{1'b0, 1'b1, 5'd31, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  1'b1};
    vecs[5]  = '{1'b0, 1'b1, 5'd12, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 5'd17, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 5'd2,  1'b0};
    vecs[8]  = '{1'b0, 1'b0, 5'd4,  1'b1};
    vecs[9]  = '{1'b1, 1'b0, 5'd6,  1'b1};
    vecs[10] = '{1'b1, 1'b1, 5'd8,  1'b1};
    vecs[11] = '{1'b1, 1'b1, 5'd10, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 5'd14, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 5'd21, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 5'd30, 1'b0};

    for (int i = 0; i < 32; i++) bank[i] = 32'h0A0B_0C00 + i;

    reset         = 1'b1;
    runMode       = 1'b0;
    stepReq       = 1'b0;
    dumpReq       = 1'b0;
    pipeAddrA     = 5'd9;
    tx_if.txReady = 1'b0;

    // Reset: two cycles with the bank enabled and all else quiet.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset_clken", 32'(clkEnable), 32'd1);
      chk("reset_txvalid", 32'(tx_if.txValid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_addr", 32'(addressA), 32'd9);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_clken", 32'(clkEnable), 32'd0);
    chk("post_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_txvalid", 32'(tx_if.txValid), 32'd0);

    // Step and run mode vectors in IDLE.
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      runMode   = vecs[k].run;
      stepReq   = vecs[k].step;
      pipeAddrA = vecs[k].addr;
      @(negedge clk);
      chk($sformatf("vec%0d_clken", k), 32'(clkEnable), 32'(vecs[k].exp_ce));
      chk($sformatf("vec%0d_addr", k), 32'(addressA), 32'(vecs[k].addr));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'd0);
    end

    // Full dump with txReady held high.
    run_dump(0, 1'b0, 0, 0, dc, dn, ce);
    chk("full_done_cycle", 32'(dc), 32'd162);
    chk("full_done_pulses", 32'(dn), 32'd1);
    chk("full_clken_cycles", 32'(ce), 32'd0);
    chk("full_bytes_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: txReady high one cycle in three.
    run_dump(1, 1'b0, 0, 0, dc, dn, ce);
    chk("bp_done_later", 32'(dc > 162), 32'd1);
    chk("bp_done_pulses", 32'(dn), 32'd1);
    chk("bp_clken_cycles", 32'(ce), 32'd0);
    chk("bp_bytes_left", 32'(exp_q.size()), 32'd0);

    // Step edge coincident with dumpReq, and dumpReq re-asserted mid-dump.
    run_dump(0, 1'b1, 50, 0, dc, dn, ce);
    chk("coll_done_cycle", 32'(dc), 32'd162);
    chk("coll_done_pulses", 32'(dn), 32'd1);
    chk("coll_clken_cycles", 32'(ce), 32'd0);
    chk("coll_bytes_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    stepReq = 1'b0;

    // Reset while register 7 is being sent.
    run_dump(0, 1'b0, 0, 39, dc, dn, ce);
    chk("abort_done_pulses", 32'(dn), 32'd0);
    chk("abort_clken_cycles", 32'(ce), 32'd0);

    // A fresh dump after the abort starts again from r0.
    run_dump(0, 1'b0, 0, 0, dc, dn, ce);
    chk("restart_done_cycle", 32'(dc), 32'd162);
    chk("restart_done_pulses", 32'(dn), 32'd1);
    chk("restart_bytes_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_debug_ctrl.md
# regfile_debug_ctrl

Debug controller for the MIPS register bank. It gates the bank's `clkEnable` in run/step modes and arbitrates read port A between the pipeline and a dump engine. On request, the dump engine halts the core and streams all 32 registers as bytes to the UART transmitter over a valid/ready handshake. The block sits between the decode stage, the register bank and the debug UART.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register word width; must be a multiple of 8.
- `REGFILE_WIDTH`, 5: register address width; `NUM_REGS = 2**REGFILE_WIDTH`.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `runMode`, in, 1: 1 = free run, 0 = single-step.
- `stepReq`, in, 1: level input; each rising edge requests one step.
- `dumpReq`, in, 1: starts a dump when sampled high in IDLE.
- `pipeAddrA`, in, `REGFILE_WIDTH`: pipeline read address for port A.
- `regA`, in, `DATA_WIDTH`: bank read data, port A.
- `addressA`, out, `REGFILE_WIDTH`: muxed address to the bank.
- `clkEnable`, out, 1: bank/pipeline clock enable.
- `txByte`, out, 8: byte to the UART.
- `txValid`, out, 1: `txByte` is valid.
- `txReady`, in, 1: UART accepts the byte this cycle.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a dump completes.

## Operation
- FSM states: IDLE, STALL, LOAD, SEND, DONE.
- **IDLE**
  - `addressA = pipeAddrA`.
  - `clkEnable` = `runMode`, or, with `runMode` = 0, a single-cycle pulse on each detected `stepReq` rising edge.
  - Edge detection uses a registered copy of `stepReq`.
  - If `dumpReq` = 1, go to STALL. Dump wins over a simultaneous step edge; that step is discarded.
- **STALL**: `clkEnable` = 0, `idx` = 0, go to LOAD.
- **LOAD**
  - `addressA = idx`.
  - `regA` is captured into a shift register at the clock edge.
  - `byteCnt` = 0; go to SEND.
- **SEND**
  - `txValid` = 1; `txByte` = shift register MSB byte (big-endian).
  - On `txReady`: shift left 8 and increment `byteCnt`.
  - After the 4th accepted byte: if `idx` = `NUM_REGS`-1, go to DONE; else increment `idx` and go to LOAD.
- **DONE**: `done` = 1 for one cycle, then go to IDLE.
- `clkEnable` = 0 in STALL, LOAD, SEND and DONE.
- `dumpReq` and `stepReq` edges are ignored while `busy`.
- The step-edge register keeps tracking during a dump. A level held high across the dump does not produce a step afterwards.
- `idx` is `REGFILE_WIDTH` bits; completion is tested on the compare, never on wrap.

## Timing
- **Values during and after reset**
  - `clkEnable` = 1 combinationally while `reset` is high, so the bank executes its own reset clear.
  - All other outputs are 0, and `addressA` = `pipeAddrA`.
  - Once `reset` falls, the FSM is in IDLE with `idx`, `byteCnt` and the step-edge register cleared.
- **Handshake**: once `txValid` rises, it and `txByte` stay stable until a cycle with `txReady` = 1. `txValid` never drops without a transfer, except on `reset`.
- **Dump latency**, with `dumpReq` sampled at edge 0 and `txReady` held at 1:
  - STALL in cycle 1, LOAD r0 in cycle 2.
  - First byte valid in cycle 3.
  - Each register costs 5 cycles.
  - `done` is high in cycle 162.
- **Step latency**: a `stepReq` rise sampled at edge n gives `clkEnable` = 1 during cycle n+1 only.
- **Reset mid-dump**: next state is IDLE; `txValid` drops immediately; the partial dump is abandoned with no `done`.

## Structure
- Package `mips_debug_pkg` holds:
  - the FSM state enum;
  - `NUM_REGS`;
  - `BYTES_PER_WORD = DATA_WIDTH/8`.
- The `mips_debug_pkg` package is shared with the future memory-dump controller.
- Sub-module `regword_serializer` contains:
  - load, shift register and `byteCnt`;
  - `txValid`/`txByte`/`txReady` handshake;
  - `last` output.
- The top level keeps the FSM, `idx`, the address mux, step-edge detection and `clkEnable` gating.

## Test plan
- **Reset**: hold `reset` 2 cycles with `runMode` = 0 → `clkEnable` = 1 during reset; then 0, IDLE, `busy` = 0, `txValid` = 0.
- **Full dump**: preload register i = 0x0A0B0C00+i, `txReady` = 1, pulse `dumpReq` → 128 bytes 0A 0B 0C 00, 0A 0B 0C 01, … 0A 0B 0C 1F. `done` in cycle 162; `clkEnable` = 0 from cycle 1 to 162.
- **Backpressure**: `txReady` toggling 1-of-3 cycles → byte stream identical and `txByte` stable while stalled; `done` is later but still a single pulse.
- **Step mode**: `runMode` = 0, 3 `stepReq` rises with 1-cycle and multi-cycle widths → exactly 3 one-cycle `clkEnable` pulses.
- **Collisions**: `stepReq` rise and `dumpReq` in the same cycle → dump runs, no step pulse. `dumpReq` re-asserted mid-dump → ignored.
- **Reset mid-dump**: assert `reset` while in SEND of r7 → next cycle IDLE, `txValid` = 0, no `done`; a new dump restarts from r0.
